// File: rtl/frame_scheduler.sv
// Per-frame sequencer: syncs vsync, paces renders, gates renderer writes and flips display buffers.
// Latency: vsync edge visible on frame_clk_edge 2 Clk after sampling; draw_start 1 Clk after the tick.
// Backpressure: display reader (mem_rd_req) always wins the shared port; wr_en drops combinationally.
// Optional render watchdog is compiled in with `define FRAME_SCHED_TIMEOUT_EN.
module frame_scheduler #(
  parameter int          FRAME_DIV       = 1,
  parameter logic [19:0] MAX_DRAW_CYCLES = 20'd1000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic        draw_done,
  input  logic        mem_rd_req,
  output logic [1:0]  frame_clk_edge,
  output logic        draw_start,
  output logic        wr_en,
  output logic        buffer_using,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  overrun_count,
  output logic        draw_abort
);

  typedef enum logic [1:0] {IDLE, DRAW, WAIT_SWAP} state_t;

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

  // Reject configurations the divider or watchdog cannot represent.
  if (FRAME_DIV < 1 || FRAME_DIV > 15) begin : g_bad_frame_div
    $error("frame_scheduler: FRAME_DIV must be in 1..15");
  end
  if (MAX_DRAW_CYCLES == 20'd0) begin : g_bad_max_draw
    $error("frame_scheduler: MAX_DRAW_CYCLES must be non-zero");
  end

  state_t     state;
  logic       sync1;
  logic       sync2;
  logic       edge_reg;
  logic [3:0] div_cnt;
  logic       tick;
  logic       eligible;
  logic       at_limit;

  // Two-flop synchroniser for the asynchronous vsync plus a delayed copy for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      edge_reg <= 1'b0;
    end else begin
      sync1    <= vsync;
      sync2    <= sync1;
      edge_reg <= sync2;
    end
  end

  assign frame_clk_edge = {edge_reg, sync2};
  assign tick           = (frame_clk_edge == 2'b01);
  assign eligible       = tick && (div_cnt == 4'd0);

  // Frame divider: every tick advances it; only ticks landing on 0 may start or swap a render.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt <= 4'd0;
    end else if (tick) begin
      div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    end
  end

`ifdef FRAME_SCHED_TIMEOUT_EN
  logic [19:0] draw_cyc;
  assign at_limit = (state == DRAW) && (draw_cyc == MAX_DRAW_CYCLES - 20'd1);
`else
  assign at_limit   = 1'b0;
  assign draw_abort = 1'b0;
`endif

  // The renderer writes only in DRAW, never in the start cycle, and yields to the display reader.
  assign wr_en = (state == DRAW) && !mem_rd_req && !draw_start && !at_limit;

  // Render sequencer; all outputs are registered alongside the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      draw_start    <= 1'b0;
      busy          <= 1'b0;
      buffer_using  <= 1'b0;
      frame_count   <= 16'd0;
      overrun_count <= 8'd0;
`ifdef FRAME_SCHED_TIMEOUT_EN
      draw_cyc      <= 20'd0;
      draw_abort    <= 1'b0;
`endif
    end else begin
      draw_start <= 1'b0;
`ifdef FRAME_SCHED_TIMEOUT_EN
      draw_abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (eligible) begin
            state      <= DRAW;
            busy       <= 1'b1;
            draw_start <= 1'b1;
`ifdef FRAME_SCHED_TIMEOUT_EN
            draw_cyc   <= 20'd0;
`endif
          end
        end
        DRAW: begin
          if (draw_done) begin
            if (eligible) begin
              // Completion coincides with the boundary: swap and restart at once.
              buffer_using <= ~buffer_using;
              frame_count  <= frame_count + 16'd1;
              draw_start   <= 1'b1;
`ifdef FRAME_SCHED_TIMEOUT_EN
              draw_cyc     <= 20'd0;
`endif
            end else begin
              state <= WAIT_SWAP;
              busy  <= 1'b0;
            end
          end else begin
            if (eligible && overrun_count != 8'hFF) begin
              overrun_count <= overrun_count + 8'd1;
            end
`ifdef FRAME_SCHED_TIMEOUT_EN
            if (at_limit) begin
              // Abandon the render; the displayed buffer and swap count stay as they are.
              state      <= IDLE;
              busy       <= 1'b0;
              draw_abort <= 1'b1;
            end else begin
              draw_cyc <= draw_cyc + 20'd1;
            end
`endif
          end
        end
        WAIT_SWAP: begin
          if (eligible) begin
            state        <= DRAW;
            busy         <= 1'b1;
            buffer_using <= ~buffer_using;
            frame_count  <= frame_count + 16'd1;
            draw_start   <= 1'b1;
`ifdef FRAME_SCHED_TIMEOUT_EN
            draw_cyc     <= 20'd0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed vector table, corner-case sequences and a randomized run,
// with every cycle of two instances (FRAME_DIV 1 and 3) compared against a frame-level model.
module tb_frame_scheduler;

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAX1 = 1000000;
  localparam int MAX3 = 50;
  localparam int P_IDLE = 0;
  localparam int P_DRAW = 1;
  localparam int P_WAIT = 2;

  logic        Clk;
  logic        Reset;
  logic        vsync;
  logic        draw_done;
  logic        draw_done3;
  logic        mem_rd_req;
  logic [1:0]  frame_clk_edge, frame_clk_edge3;
  logic        draw_start, draw_start3;
  logic        wr_en, wr_en3;
  logic        buffer_using, buffer_using3;
  logic        busy, busy3;
  logic [15:0] frame_count, frame_count3;
  logic [7:0]  overrun_count, overrun_count3;
  logic        draw_abort, draw_abort3;

  frame_scheduler #(.FRAME_DIV(1), .MAX_DRAW_CYCLES(20'd1000000)) dut (
    .Clk(Clk), .Reset(Reset), .vsync(vsync), .draw_done(draw_done), .mem_rd_req(mem_rd_req),
    .frame_clk_edge(frame_clk_edge), .draw_start(draw_start), .wr_en(wr_en),
    .buffer_using(buffer_using), .busy(busy), .frame_count(frame_count),
    .overrun_count(overrun_count), .draw_abort(draw_abort)
  );

  frame_scheduler #(.FRAME_DIV(3), .MAX_DRAW_CYCLES(20'd50)) dut3 (
    .Clk(Clk), .Reset(Reset), .vsync(vsync), .draw_done(draw_done3), .mem_rd_req(mem_rd_req),
    .frame_clk_edge(frame_clk_edge3), .draw_start(draw_start3), .wr_en(wr_en3),
    .buffer_using(buffer_using3), .busy(busy3), .frame_count(frame_count3),
    .overrun_count(overrun_count3), .draw_abort(draw_abort3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level view of one scheduler: how many ticks seen, what the renderer is doing.
  typedef struct {
    int ticks;
    int phase;
    int cyc;
    bit start;
    bit buf_sel;
    int fc;
    int oc;
    bit abort;
  } mdl_t;

  typedef struct {
    int         n;
    bit         v;
    bit         dd;
    logic [1:0] e_edge;
    bit         e_start;
    bit         e_busy;
    bit         e_buf;
    int         e_fc;
    int         e_oc;
  } vec_t;

  mdl_t       m1, m3;
  bit         vq[$];
  logic [1:0] edge_m;
  logic       last_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.ticks = 0; r.phase = P_IDLE; r.cyc = 0; r.start = 0;
    r.buf_sel = 0; r.fc = 0; r.oc = 0; r.abort = 0;
    return r;
  endfunction

  // One clock of the frame rules: e is the edge code seen in the cycle being closed.
  function automatic mdl_t step(input mdl_t m, input logic [1:0] e, input bit rst,
                                input bit dd, input int div, input int maxc);
    mdl_t n;
    bit   tk, elig, restart;
    if (rst) return mdl_reset();
    n = m;
    n.start = 0;
    n.abort = 0;
    restart = 0;
    tk   = (e == 2'b01);
    elig = tk && (m.ticks % div == 0);
    if (tk) n.ticks = m.ticks + 1;
    if (m.phase == P_IDLE) begin
      if (elig) restart = 1;
    end else if (m.phase == P_DRAW) begin
      if (dd) begin
        if (elig) begin
          n.buf_sel = !m.buf_sel;
          n.fc = (m.fc + 1) % 65536;
          restart = 1;
        end else begin
          n.phase = P_WAIT;
        end
      end else begin
        if (elig && m.oc < 255) n.oc = m.oc + 1;
        if (TO_EN && m.cyc == maxc - 1) begin
          n.abort = 1;
          n.phase = P_IDLE;
        end else begin
          n.cyc = m.cyc + 1;
        end
      end
    end else begin
      if (elig) begin
        n.buf_sel = !m.buf_sel;
        n.fc = (m.fc + 1) % 65536;
        restart = 1;
      end
    end
    if (restart) begin
      n.phase = P_DRAW;
      n.start = 1;
      n.cyc = 0;
    end
    return n;
  endfunction

  function automatic logic exp_wr(input mdl_t m, input bit rd, input int maxc);
    return (m.phase == P_DRAW) && !rd && !m.start && !(TO_EN && m.cyc == maxc - 1);
  endfunction

  // Drive one cycle of inputs, check wr_en mid-cycle, clock, then check registered outputs.
  task automatic cycle(input bit rst, input bit v, input bit dd, input bit rd, input bit dd3);
    logic [1:0] e_pre;
    Reset = rst; vsync = v; draw_done = dd; mem_rd_req = rd; draw_done3 = dd3;
    #1;
    chk("wr_en", wr_en, exp_wr(m1, rd, MAX1));
    chk("wr_en3", wr_en3, exp_wr(m3, rd, MAX3));
    last_wr = wr_en;
    @(posedge Clk);
    e_pre = edge_m;
    m1 = step(m1, e_pre, rst, dd, 1, MAX1);
    m3 = step(m3, e_pre, rst, dd3, 3, MAX3);
    if (rst) begin
      vq = '{1'b0, 1'b0, 1'b0};
    end else begin
      vq.push_back(v);
      void'(vq.pop_front());
    end
    edge_m = {vq[0], vq[1]};
    #1;
    chk("edge", frame_clk_edge, edge_m);
    chk("start", draw_start, m1.start);
    chk("busy", busy, m1.phase == P_DRAW);
    chk("buf", buffer_using, m1.buf_sel);
    chk("fc", frame_count, m1.fc);
    chk("oc", overrun_count, m1.oc);
    chk("abort", draw_abort, m1.abort);
    chk("edge3", frame_clk_edge3, edge_m);
    chk("start3", draw_start3, m3.start);
    chk("busy3", busy3, m3.phase == P_DRAW);
    chk("buf3", buffer_using3, m3.buf_sel);
    chk("fc3", frame_count3, m3.fc);
    chk("oc3", overrun_count3, m3.oc);
    chk("abort3", draw_abort3, m3.abort);
  endtask

  initial begin
    vec_t tbl[26];
    int   wr_hi;
    int   s_cnt;
    int   cnt;
    bit   started;
    bit   seen;
    bit   vr;
    int   hold;

    // n, vsync, draw_done, edge, start, busy, buf, frame_count, overrun_count
    tbl[0]  = '{5,  0, 0, 2'b00, 0, 0, 0, 0, 0};
    tbl[1]  = '{2,  1, 0, 2'b01, 0, 0, 0, 0, 0};
    tbl[2]  = '{1,  1, 0, 2'b11, 1, 1, 0, 0, 0};
    tbl[3]  = '{1,  1, 0, 2'b11, 0, 1, 0, 0, 0};
    tbl[4]  = '{97, 1, 0, 2'b11, 0, 1, 0, 0, 0};
    tbl[5]  = '{1,  1, 1, 2'b11, 0, 0, 0, 0, 0};
    tbl[6]  = '{20, 0, 0, 2'b00, 0, 0, 0, 0, 0};
    tbl[7]  = '{2,  1, 0, 2'b01, 0, 0, 0, 0, 0};
    tbl[8]  = '{1,  1, 0, 2'b11, 1, 1, 1, 1, 0};
    tbl[9]  = '{50, 1, 0, 2'b11, 0, 1, 1, 1, 0};
    tbl[10] = '{1,  1, 1, 2'b11, 0, 0, 1, 1, 0};
    tbl[11] = '{20, 0, 0, 2'b00, 0, 0, 1, 1, 0};
    tbl[12] = '{3,  1, 0, 2'b11, 1, 1, 0, 2, 0};
    tbl[13] = '{10, 0, 0, 2'b00, 0, 1, 0, 2, 0};
    tbl[14] = '{10, 1, 0, 2'b11, 0, 1, 0, 2, 1};
    tbl[15] = '{10, 0, 0, 2'b00, 0, 1, 0, 2, 1};
    tbl[16] = '{10, 1, 0, 2'b11, 0, 1, 0, 2, 2};
    tbl[17] = '{10, 0, 0, 2'b00, 0, 1, 0, 2, 2};
    tbl[18] = '{10, 1, 0, 2'b11, 0, 1, 0, 2, 3};
    tbl[19] = '{1,  1, 1, 2'b11, 0, 0, 0, 2, 3};
    tbl[20] = '{10, 0, 0, 2'b00, 0, 0, 0, 2, 3};
    tbl[21] = '{2,  1, 0, 2'b01, 0, 0, 0, 2, 3};
    tbl[22] = '{1,  1, 0, 2'b11, 1, 1, 1, 3, 3};
    tbl[23] = '{10, 0, 0, 2'b00, 0, 1, 1, 3, 3};
    tbl[24] = '{2,  1, 0, 2'b01, 0, 1, 1, 3, 3};
    tbl[25] = '{1,  1, 1, 2'b11, 1, 1, 0, 4, 3};

    Reset = 1; vsync = 0; draw_done = 0; draw_done3 = 0; mem_rd_req = 0;
    repeat (2) @(posedge Clk);
    #1;
    m1 = mdl_reset();
    m3 = mdl_reset();
    vq = '{1'b0, 1'b0, 1'b0};
    edge_m = 2'b00;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    chk("reset.edge", frame_clk_edge, 0);
    chk("reset.buf", buffer_using, 0);
    chk("reset.fc", frame_count, 0);
    chk("reset.oc", overrun_count, 0);
    chk("reset.wr", wr_en, 0);

    // Directed frame sequence: start, swaps, overruns, done-on-tick
    for (int r = 0; r < 26; r++) begin
      for (int k = 0; k < tbl[r].n; k++) cycle(0, tbl[r].v, tbl[r].dd, 0, 0);
      chk($sformatf("tbl%0d.edge", r), frame_clk_edge, tbl[r].e_edge);
      chk($sformatf("tbl%0d.start", r), draw_start, tbl[r].e_start);
      chk($sformatf("tbl%0d.busy", r), busy, tbl[r].e_busy);
      chk($sformatf("tbl%0d.buf", r), buffer_using, tbl[r].e_buf);
      chk($sformatf("tbl%0d.fc", r), frame_count, tbl[r].e_fc);
      chk($sformatf("tbl%0d.oc", r), overrun_count, tbl[r].e_oc);
    end

    // Reader priority window inside DRAW
    cycle(0, 1, 0, 0, 0);
    wr_hi = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 1, 0, (i >= 10 && i < 20), 0);
      chk($sformatf("rd_gap.wr%0d", i), last_wr, !(i >= 10 && i < 20));
      if (last_wr === 1'b1) wr_hi++;
    end
    chk("rd_gap.count", wr_hi, 20);
    chk("rd_gap.buf", buffer_using, 0);
    chk("rd_gap.busy", busy, 1);

    // Reset in the middle of a render
    cycle(1, 1, 0, 0, 0);
    chk("midreset.edge", frame_clk_edge, 0);
    chk("midreset.busy", busy, 0);
    chk("midreset.buf", buffer_using, 0);
    chk("midreset.fc", frame_count, 0);
    chk("midreset.oc", overrun_count, 0);
    chk("midreset.wr", wr_en, 0);

    // Overrun saturation: one tick to start, then 300 missed ticks
    repeat (4) cycle(0, 0, 0, 0, 0);
    for (int t = 0; t < 301; t++) begin
      repeat (4) cycle(0, 1, 0, 0, 0);
      repeat (4) cycle(0, 0, 0, 0, 0);
    end
    chk("sat.oc", overrun_count, 255);
    chk("sat.busy", busy, 1);
    cycle(0, 0, 1, 0, 0);
    chk("sat.oc_after", overrun_count, 255);
    chk("sat.busy_after", busy, 0);

    // FRAME_DIV=3: starts only on ticks 1, 4, 7
    cycle(1, 0, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 0);
    for (int t = 1; t <= 9; t++) begin
      s_cnt = 0;
      started = 0;
      for (int j = 1; j <= 6; j++) begin
        cycle(0, 1, 0, 0, (j == 5) && started);
        if (draw_start3 === 1'b1) begin
          s_cnt++;
          if (j == 3) started = 1;
        end
      end
      for (int j = 0; j < 6; j++) begin
        cycle(0, 0, 0, 0, 0);
        if (draw_start3 === 1'b1) s_cnt++;
      end
      chk($sformatf("div3.tick%0d.starts", t), s_cnt, (t == 1 || t == 4 || t == 7) ? 1 : 0);
    end
    chk("div3.fc", frame_count3, 2);

    // Watchdog on the MAX_DRAW_CYCLES=50 instance
    cycle(1, 0, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 0);
    chk("wd.start", draw_start3, 1);
    cnt = 0;
    seen = 0;
`ifdef FRAME_SCHED_TIMEOUT_EN
    while (!seen && cnt < 200) begin
      cycle(0, 1, 0, 0, 0);
      cnt++;
      if (draw_abort3 === 1'b1) seen = 1;
    end
    chk("wd.abort_delay", cnt, 50);
    chk("wd.busy", busy3, 0);
    chk("wd.buf", buffer_using3, 0);
    chk("wd.fc", frame_count3, 0);
    cycle(0, 1, 0, 0, 0);
    chk("wd.abort_width", draw_abort3, 0);
`else
    for (int i = 0; i < 100; i++) begin
      cycle(0, 1, 0, 0, 0);
      if (draw_abort3 !== 1'b0) cnt++;
    end
    chk("wd.no_abort", cnt, 0);
    chk("wd.still_busy", busy3, 1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i += hold) begin
      hold = $urandom_range(1, 12);
      vr = 1'($urandom_range(0, 1));
      for (int j = 0; j < hold; j++) begin
        cycle($urandom_range(0, 499) == 0, vr, $urandom_range(0, 39) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Per-frame sequencer for the double-buffered pixel renderer.
- Synchronises VGA vsync into Clk and produces the frame edge code consumed by the drawing engine.
- Issues a start pulse for each frame, gates the renderer's write enable against display-read traffic on the shared frame-buffer port, and flips the displayed buffer only on a completed render at a frame boundary.
- Sits between the VGA controller, the drawing engine and the frame-buffer memory.

Parameters:
- FRAME_DIV, 1: render on every Nth eligible frame tick; legal range 1..15.
- MAX_DRAW_CYCLES, 20'd1000000: watchdog limit in Clk cycles per render; used only with FRAME_SCHED_TIMEOUT_EN.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high
- vsync  input  1  VGA vertical sync, asynchronous to Clk, active-low
- draw_done  input  1  one-cycle pulse from drawing engine: frame fully written
- mem_rd_req  input  1  display reader needs the frame-buffer port this cycle; reader has priority
- frame_clk_edge  output  2  {previous, current} synchronised vsync; 2'b01 = rising edge
- draw_start  output  1  one-cycle pulse: begin rendering a new frame
- wr_en  output  1  renderer may advance and write one pixel this cycle
- buffer_using  output  1  buffer being displayed; renderer writes ~buffer_using
- busy  output  1  high while in DRAW
- frame_count  output  16  completed swaps, wraps at 16'hFFFF -> 0
- overrun_count  output  8  frame ticks missed while drawing; saturates at 255
- draw_abort  output  1  one-cycle pulse on watchdog expiry; tied 0 without the macro

Behaviour:
- Reset values: all outputs 0, vsync synchroniser cleared, divider counter 0, state IDLE.
- Synchroniser:
  - Two flops on vsync, then an edge register.
  - frame_clk_edge = {edge_reg, sync2}, all registered.
- Frame ticks:
  - A tick is the cycle in which frame_clk_edge == 2'b01.
  - The divider counts ticks, counting 0 .. FRAME_DIV-1 and wrapping to 0.
  - A tick is eligible when the divider is at 0 during the tick; the divider advances on every tick.
- FSM states: IDLE, DRAW, WAIT_SWAP.
  - IDLE: on an eligible tick, pulse draw_start in the next cycle and go to DRAW. No swap happens.
  - DRAW:
    - busy = 1.
    - wr_en = ~mem_rd_req, combinational from mem_rd_req and state.
    - On draw_done, go to WAIT_SWAP.
    - On an eligible tick without draw_done, overrun_count += 1 (saturating) and stay in DRAW.
    - Display is unchanged during DRAW.
  - WAIT_SWAP:
    - wr_en = 0, busy = 0.
    - On an eligible tick: toggle buffer_using, frame_count += 1, pulse draw_start the next cycle, go to DRAW.
- Simultaneous events:
  - draw_done in the same cycle as an eligible tick in DRAW counts as completion, not overrun. Swap and restart immediately, exactly as if coming from WAIT_SWAP.
  - draw_done outside DRAW is ignored.
- draw_start:
  - Exactly one cycle wide, one cycle after the tick that caused it.
  - Never asserted while wr_en is high in the same cycle.
- Reset mid-operation: returns to reset values in the next cycle. A render in progress is discarded and buffer_using returns to 0.

Optional Feature:
- Macro: FRAME_SCHED_TIMEOUT_EN.
- When defined:
  - A 20-bit cycle counter is cleared on draw_start and increments each DRAW cycle.
  - On reaching MAX_DRAW_CYCLES-1 without draw_done: pulse draw_abort for one cycle, force wr_en = 0, go to IDLE.
  - buffer_using and frame_count are not changed.
- When undefined: no counter is built, draw_abort is constant 0, and DRAW waits indefinitely.

Test Plan:
- Reset, vsync toggling, draw_done pulsed 100 cycles after each draw_start, FRAME_DIV=1:
  - first tick -> draw_start at tick+1 with no swap;
  - second tick -> buffer_using 0->1, frame_count=1;
  - third tick -> buffer_using=0, frame_count=2.
- DRAW with mem_rd_req high for cycles 10-19 -> wr_en low exactly those 10 cycles and high otherwise; buffer_using unchanged.
- No draw_done for 3 ticks, then draw_done -> overrun_count=3, no swap until the following tick. Hold draw_done off for 300 ticks -> overrun_count stays 255.
- draw_done asserted in the same cycle as a tick -> overrun_count unchanged, buffer_using toggles, draw_start pulses next cycle.
- FRAME_DIV=3 with 9 ticks and prompt draw_done -> draw_start at ticks 1, 4 and 7 only; frame_count=2.
- FRAME_SCHED_TIMEOUT_EN, MAX_DRAW_CYCLES=50, no draw_done -> draw_abort pulse 50 cycles after draw_start, state IDLE, buffer_using unchanged. Reset asserted mid-DRAW -> all outputs 0 next cycle.
